mem_addr_gen: RTL and testbench

Registered memory-address generator for the multicycle CPU datapath. It is the parametrised successor of the memory-address selector.
- Selects a base address from PC/ALU-side sources or fixed exception-vector addresses.
- Registers the selected address and steps through a multi-beat burst under a start/ack handshake.
- Sits between the control unit and the memory address port.
- Illegal selects are flagged; the output is never left undriven.

---
 rtl/mem_addr_gen.sv | 92 +++++++++
 tb/tb_mem_addr_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: registered memory-address generator with vector selects and acked bursts
// Ports: clk_i clock; rst_ni async active-low reset; sel_i source select; data_{0,1,5,6}_i sources;
//        start_i/burst_len_i request; mem_ack_i/abort_i burst control;
//        addr_out_o, addr_valid_o, busy_o, done_o, illegal_sel_o status.
module mem_addr_gen #(
   parameter int WIDTH    = 32,
   parameter int VEC_BASE = 253,
   parameter int STEP     = 4,
   parameter int LEN_W    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [2:0]       sel_i,
   input  logic [WIDTH-1:0] data_0_i,
   input  logic [WIDTH-1:0] data_1_i,
   input  logic [WIDTH-1:0] data_5_i,
   input  logic [WIDTH-1:0] data_6_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] burst_len_i,
   input  logic             mem_ack_i,
   input  logic             abort_i,
   output logic [WIDTH-1:0] addr_out_o,
   output logic             addr_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             illegal_sel_o
);
   typedef enum logic {IDLE, BURST} state_e;
   state_e state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d, src;
   logic [LEN_W-1:0] beats_q, beats_d;
   logic valid_q, valid_d, done_q, done_d, ill_q, ill_d, is_vec;
   assign is_vec = sel_i inside {3'd2, 3'd3, 3'd4};
   // sel 2..4 map onto consecutive vector addresses; sel 7 never reaches addr_d
   assign src = sel_i == 3'd0 ? data_0_i :
                sel_i == 3'd1 ? data_1_i :
                sel_i == 3'd5 ? data_5_i :
                sel_i == 3'd6 ? data_6_i :
                WIDTH'(VEC_BASE) + WIDTH'(sel_i - 3'd2);
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      if (state_q == IDLE) begin
         if (start_i && sel_i == 3'd7) ill_d = 1'b1;
         else if (start_i) begin
            state_d = BURST;
            addr_d  = src;
            valid_d = 1'b1;
            // vectors are single-beat; a zero length still means one beat
            beats_d = (is_vec || burst_len_i == '0) ? '0 : burst_len_i - LEN_W'(1);
         end
      end else if (abort_i) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else if (mem_ack_i) begin
         if (beats_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
         end else begin
            addr_d  = addr_q + WIDTH'(STEP);
            beats_d = beats_q - LEN_W'(1);
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beats_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
      end
   end
   assign addr_out_o    = addr_q;
   assign addr_valid_o  = valid_q;
   assign busy_o        = state_q == BURST;
   assign done_o        = done_q;
   assign illegal_sel_o = ill_q;
endmodule

// File: tb/tb_mem_addr_gen.sv
// tb_mem_addr_gen: randomized self-checking bench for mem_addr_gen against a burst-level model
module tb_mem_addr_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  sel = '0;
   logic [31:0] d0 = '0, d1 = '0, d5 = '0, d6 = '0;
   logic        start = 1'b0;
   logic [3:0]  blen = '0;
   logic        ack = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] addr;
   logic        valid, busy, done, ill;
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model_addr = '0;

   mem_addr_gen dut (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel),
      .data_0_i(d0), .data_1_i(d1), .data_5_i(d5), .data_6_i(d6),
      .start_i(start), .burst_len_i(blen), .mem_ack_i(ack), .abort_i(abort),
      .addr_out_o(addr), .addr_valid_o(valid), .busy_o(busy), .done_o(done), .illegal_sel_o(ill)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      #3;
      vectors++;
      if ({addr, valid, busy, done, ill} !== 36'd0) begin
         miscompares++;
         $display("FAIL reset: addr=%h v=%b b=%b d=%b i=%b required all zero", addr, valid, busy, done, ill);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_addr = '0;
      @(negedge clk);
   endtask

   // Start a burst at the current negedge; ack_pct<0 selects an ack on every fourth cycle.
   // abort_at>=0 raises abort together with the ack for that beat.
   task automatic run_burst(input logic [2:0] s, input logic [31:0] src, input logic [3:0] len,
                            input int ack_pct, input int abort_at);
      logic [31:0] base, exp;
      int nbeats, beat, cyc;
      bit a, ab;
      base = (s inside {3'd2, 3'd3, 3'd4}) ? 32'd253 + 32'(s) - 32'd2 : src;
      nbeats = (s inside {3'd2, 3'd3, 3'd4}) ? 1 : (len == 0 ? 1 : int'(len));
      d0 = $urandom; d1 = $urandom; d5 = $urandom; d6 = $urandom;
      case (s)
         3'd0: d0 = src;
         3'd1: d1 = src;
         3'd5: d5 = src;
         3'd6: d6 = src;
         default: ;
      endcase
      sel = s; blen = len; start = 1'b1;
      @(negedge clk);
      d0 = $urandom; d1 = $urandom; d5 = $urandom; d6 = $urandom;
      beat = 0; cyc = 0; ab = 0;
      while (beat < nbeats && !ab && cyc < 300) begin
         exp = base + 32'(beat) * 32'd4;
         vectors++;
         if (addr !== exp || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || ill !== 1'b0) begin
            miscompares++;
            $display("FAIL beat%0d: addr=%h v=%b b=%b d=%b i=%b required addr=%h v=1 b=1 d=0 i=0",
                     beat, addr, valid, busy, done, ill, exp);
         end
         ack = ack_pct < 0 ? (cyc % 4 == 3) : ($urandom_range(99) < ack_pct);
         a = (beat == abort_at) && ack;
         abort = a;
         start = $urandom_range(1);
         sel = 3'($urandom_range(7));
         blen = 4'($urandom);
         @(negedge clk);
         cyc++;
         if (a) ab = 1;
         else if (ack) beat++;
      end
      ack = 1'b0; abort = 1'b0; start = 1'b0;
      if (cyc >= 300) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: burst did not complete, beat=%0d required %0d", beat, nbeats);
      end
      exp = base + 32'(ab ? beat : beat - 1) * 32'd4;
      model_addr = exp;
      vectors++;
      if (addr !== exp || valid !== 1'b0 || busy !== 1'b0 || done !== !ab || ill !== 1'b0) begin
         miscompares++;
         $display("FAIL end: addr=%h v=%b b=%b d=%b i=%b required addr=%h v=0 b=0 d=%b i=0",
                  addr, valid, busy, done, ill, exp, !ab);
      end
   endtask

   task automatic test_illegal();
      sel = 3'd7; start = 1'b1; blen = 4'd3;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (ill !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || addr !== model_addr) begin
         miscompares++;
         $display("FAIL illegal: i=%b v=%b b=%b addr=%h required i=1 v=0 b=0 addr=%h",
                  ill, valid, busy, addr, model_addr);
      end
      @(negedge clk);
      vectors++;
      if (ill !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_pulse: i=%b b=%b required i=0 b=0", ill, busy);
      end
   endtask

   task automatic test_mid_reset();
      sel = 3'd0; d0 = 32'h0000_2000; blen = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ack = 1'b0;
      vectors++;
      if (addr !== 32'h0000_2008 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset: addr=%h b=%b required addr=00002008 b=1", addr, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({addr, valid, busy, done, ill} !== 36'd0) begin
         miscompares++;
         $display("FAIL async_reset: addr=%h v=%b b=%b d=%b i=%b required all zero", addr, valid, busy, done, ill);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_addr = '0;
      @(negedge clk);
      vectors++;
      if ({addr, valid, busy, done, ill} !== 36'd0) begin
         miscompares++;
         $display("FAIL post_reset: addr=%h v=%b b=%b d=%b i=%b required all zero", addr, valid, busy, done, ill);
      end
   endtask

   task automatic test_random();
      logic [2:0] s;
      for (int n = 0; n < 40; n++) begin
         s = 3'($urandom_range(6));
         run_burst(s, $urandom, 4'($urandom), int'($urandom_range(100, 30)),
                   ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1);
      end
   endtask

   initial begin
      test_reset();
      run_burst(3'd0, 32'h0000_1000, 4'd3, 100, -1);
      run_burst(3'd3, 32'h0, 4'd5, 100, -1);
      test_illegal();
      run_burst(3'd1, 32'hFFFF_FFFC, 4'd2, 100, -1);
      run_burst(3'd5, 32'h0000_4000, 4'd4, -1, 2);
      run_burst(3'd6, 32'h0000_5000, 4'd4, -1, -1);
      test_mid_reset();
      run_burst(3'd6, 32'h0000_3000, 4'd0, 100, -1);
      run_burst(3'd2, 32'h0, 4'd15, 50, -1);
      run_burst(3'd4, 32'h0, 4'd0, 50, -1);
      test_illegal();
      test_random();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
